adc_link_ctrl: RTL

Bring-up and link-maintenance sequencer for the 8-lane LVDS ADC capture path, clocked on the divided capture clock (CLKDIV). It resets the ISERDES datapath, enables capture, and issues single-cycle bitslip pulses until the frame-clock word matches the expected pattern for a programmable number of consecutive cycles. Once locked it watches for loss of frame alignment. It retries with a full datapath reset and reports a hard failure after a bounded number of attempts.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_link_timer.sv | 26 ++
 rtl/adc_link_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encoding and defaults for the ADC link sequencer
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESET  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        SLIP   = 3'd4,
        LOCKED = 3'd5,
        FAIL   = 3'd6
    } link_state_e;

    localparam logic [7:0] FRAME_PATTERN_DEFAULT = 8'hF0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_link_timer.sv
// rtl/adc_link_timer.sv - loadable saturating down-counter; o_done while the count is zero
module adc_link_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/adc_link_ctrl.sv
// rtl/adc_link_ctrl.sv - ISERDES reset/bitslip/lock sequencer for the LVDS ADC link
// ADC_LINK_STATS_EN adds saturating relock_total and slip_total outputs.
module adc_link_ctrl
    import adc_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = FRAME_PATTERN_DEFAULT,
    parameter int         RST_CYCLES    = 16,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         LOCK_COUNT    = 16,
    parameter int         LOSS_COUNT    = 4,
    parameter int         MAX_SLIPS     = 8,
    parameter int         MAX_RETRIES   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [7:0]                       frm_data,
    output logic                             adc_rst,
    output logic                             adc_en,
    output logic                             bitslip,
    output logic                             aligned,
    output logic                             fail,
    output logic                             relock,
    output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_cnt,
    output logic [2:0]                       state_o
`ifdef ADC_LINK_STATS_EN
    ,
    output logic [15:0]                      relock_total,
    output logic [15:0]                      slip_total
`endif
);

    localparam int SW = $clog2(MAX_SLIPS + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam int TW = $clog2(max2(RST_CYCLES, SETTLE_CYCLES) + 1);

    link_state_e r_state;
    link_state_e w_next;

    logic [SW-1:0] r_slip_cnt;
    logic [MW-1:0] r_match_cnt;
    logic [LW-1:0] r_loss_cnt;
    logic [RW-1:0] r_retry_cnt;

    logic r_adc_rst, r_adc_en, r_bitslip, r_aligned, r_fail, r_relock;
    logic w_adc_rst, w_adc_en, w_bitslip, w_aligned, w_fail, w_relock;

    logic          w_match;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_done;
    logic          w_enter_reset;
    logic          w_enter_slip;

    assign w_match       = (frm_data == FRAME_PATTERN);
    assign w_enter_reset = (w_next == RESET) && (r_state != RESET);
    assign w_enter_slip  = (w_next == SLIP) && (r_state != SLIP);

    // The timer is reloaded on every entry to a timed state, so RESET and SETTLE share it.
    assign w_tmr_load = ((w_next == RESET) || (w_next == SETTLE)) && (w_next != r_state);
    assign w_tmr_val  = (w_next == RESET) ? TW'(RST_CYCLES - 1) : TW'(SETTLE_CYCLES - 1);

    adc_link_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!start) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:   w_next = RESET;
                RESET:  if (w_tmr_done) w_next = SETTLE;
                SETTLE: if (w_tmr_done) w_next = CHECK;
                CHECK: begin
                    if (w_match) begin
                        if (r_match_cnt >= MW'(LOCK_COUNT - 1)) w_next = LOCKED;
                    end else if (r_slip_cnt < SW'(MAX_SLIPS)) begin
                        w_next = SLIP;
                    end else if (r_retry_cnt < RW'(MAX_RETRIES)) begin
                        w_next = RESET;
                    end else begin
                        w_next = FAIL;
                    end
                end
                SLIP:   w_next = SETTLE;
                LOCKED: if (!w_match && (r_loss_cnt >= LW'(LOSS_COUNT - 1))) w_next = CHECK;
                FAIL:   w_next = FAIL;
                default: w_next = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change with the state.
    always_comb begin
        w_adc_rst = 1'b0;
        w_adc_en  = 1'b0;
        w_bitslip = 1'b0;
        w_aligned = 1'b0;
        w_fail    = 1'b0;
        case (w_next)
            SETTLE, CHECK: w_adc_en = 1'b1;
            SLIP: begin
                w_adc_en  = 1'b1;
                w_bitslip = 1'b1;
            end
            LOCKED: begin
                w_adc_en  = 1'b1;
                w_aligned = 1'b1;
            end
            FAIL: begin
                w_adc_rst = 1'b1;
                w_fail    = 1'b1;
            end
            default: w_adc_rst = 1'b1;
        endcase
        w_relock = (r_state == LOCKED) && (w_next == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_rst <= 1'b1;
            r_adc_en  <= 1'b0;
            r_bitslip <= 1'b0;
            r_aligned <= 1'b0;
            r_fail    <= 1'b0;
            r_relock  <= 1'b0;
        end else begin
            r_adc_rst <= w_adc_rst;
            r_adc_en  <= w_adc_en;
            r_bitslip <= w_bitslip;
            r_aligned <= w_aligned;
            r_fail    <= w_fail;
            r_relock  <= w_relock;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slip_cnt  <= '0;
            r_match_cnt <= '0;
            r_loss_cnt  <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (w_enter_reset || w_relock) begin
                r_slip_cnt <= '0;
            end else if (w_enter_slip && (r_slip_cnt != SW'(MAX_SLIPS))) begin
                r_slip_cnt <= r_slip_cnt + 1'b1;
            end

            if (w_enter_reset || w_relock) begin
                r_match_cnt <= '0;
            end else if (r_state == CHECK) begin
                if (!w_match) begin
                    r_match_cnt <= '0;
                end else if (r_match_cnt != MW'(LOCK_COUNT)) begin
                    r_match_cnt <= r_match_cnt + 1'b1;
                end
            end

            if (((w_next == IDLE) && (r_state != IDLE)) || w_relock) begin
                r_retry_cnt <= '0;
            end else if ((r_state == CHECK) && w_enter_reset &&
                         (r_retry_cnt != RW'(MAX_RETRIES))) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end

            if ((r_state != LOCKED) || (w_next != LOCKED) || w_match) begin
                r_loss_cnt <= '0;
            end else if (r_loss_cnt != LW'(LOSS_COUNT)) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end
    end

`ifdef ADC_LINK_STATS_EN
    logic [15:0] r_relock_total;
    logic [15:0] r_slip_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_relock_total <= '0;
            r_slip_total   <= '0;
        end else begin
            if (w_relock && (r_relock_total != 16'hFFFF)) begin
                r_relock_total <= r_relock_total + 1'b1;
            end
            if (w_enter_slip && (r_slip_total != 16'hFFFF)) begin
                r_slip_total <= r_slip_total + 1'b1;
            end
        end
    end

    assign relock_total = r_relock_total;
    assign slip_total   = r_slip_total;
`endif

    assign adc_rst  = r_adc_rst;
    assign adc_en   = r_adc_en;
    assign bitslip  = r_bitslip;
    assign aligned  = r_aligned;
    assign fail     = r_fail;
    assign relock   = r_relock;
    assign slip_cnt = r_slip_cnt;
    assign state_o  = r_state;

endmodule
